avalon_pio_bidir: RTL

AVALON_PIO_BIDIR -- requirements
Module: avalon_pio_bidir

---
 rtl/avalon_pio_pkg.sv | 31 +++
 rtl/pio_sync.sv | 26 ++
 rtl/avalon_pio_bidir.sv | 112 +++++++++++
 3 files changed

// File: rtl/avalon_pio_pkg.sv
// Shared constants for the bidirectional Avalon PIO: register addresses,
// edge-capture mode encodings and the edge-select helper.
package avalon_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_DIR      = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK  = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP  = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Unknown mode encodings fall back to rising-edge capture.
  function automatic logic [31:0] edge_select(input int edge_type,
                                              input logic [31:0] sync_now,
                                              input logic [31:0] sync_prev);
    logic [31:0] rise;
    logic [31:0] fall;
    rise = sync_now & ~sync_prev;
    fall = ~sync_now & sync_prev;
    case (edge_type)
      EDGE_FALL: return fall;
      EDGE_ANY:  return rise | fall;
      default:   return rise;
    endcase
  endfunction

endpackage

// File: rtl/pio_sync.sv
// Per-bit multi-flop synchroniser bringing the asynchronous pins into the clk
// domain; o_sync is the last stage.
module pio_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_stage [SYNC_STAGES];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_async;
      for (int i = 1; i < SYNC_STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_sync = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/avalon_pio_bidir.sv
// Bidirectional Avalon-MM PIO: output data with set/clear aliases, per-bit
// direction, synchronised inputs with edge capture and a masked level IRQ.
module avalon_pio_bidir
  import avalon_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               EDGE_TYPE   = EDGE_RISE,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  // Bus semantics: a write commits on the clk edge where chipselect=1 and
  // write_n=0; readdata is registered, returns the addressed register one
  // cycle after the address is presented, and is 0 while chipselect=0.
  logic             w_wr;
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clear;
  logic [WIDTH-1:0] w_rd_mux;

  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;
  logic [WIDTH-1:0] r_sync_prev;
  logic [WIDTH-1:0] r_readdata;
  logic             r_irq;

  assign w_wr = chipselect & ~write_n;

  pio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (clk),
    .i_reset (reset),
    .i_async (in_port),
    .o_sync  (w_sync)
  );

  assign w_edge = WIDTH'(edge_select(EDGE_TYPE, 32'(w_sync), 32'(r_sync_prev)));

  always_comb begin
    w_clear = '0;
    if (w_wr && address == ADDR_EDGECAP) w_clear = writedata;
  end

  always_comb begin
    w_rd_mux = '0;
    if (chipselect) begin
      case (address)
        ADDR_DATA:     w_rd_mux = w_sync;
        ADDR_DIR:      w_rd_mux = r_dir;
        ADDR_IRQMASK:  w_rd_mux = r_irqmask;
        ADDR_EDGECAP:  w_rd_mux = r_edgecap;
        ADDR_OUTSET,
        ADDR_OUTCLEAR: w_rd_mux = r_data_out;
        default:       w_rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_out <= RESET_VALUE;
      r_dir      <= '0;
      r_irqmask  <= '0;
    end else if (w_wr) begin
      case (address)
        ADDR_DATA:     r_data_out <= writedata;
        ADDR_DIR:      r_dir      <= writedata;
        ADDR_IRQMASK:  r_irqmask  <= writedata;
        ADDR_OUTSET:   r_data_out <= r_data_out | writedata;
        ADDR_OUTCLEAR: r_data_out <= r_data_out & ~writedata;
        default:       ;
      endcase
    end
  end

  // A fresh edge is ORed in after the clear so it survives a coincident W1C.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync_prev <= '0;
      r_edgecap   <= '0;
      r_irq       <= 1'b0;
      r_readdata  <= '0;
    end else begin
      r_sync_prev <= w_sync;
      r_edgecap   <= (r_edgecap & ~w_clear) | w_edge;
      r_irq       <= |(r_edgecap & r_irqmask);
      r_readdata  <= w_rd_mux;
    end
  end

  assign out_port = r_data_out;
  assign oe       = r_dir;
  assign irq      = r_irq;
  assign readdata = r_readdata;

endmodule
